// File: rtl/seg_pkg.sv
// Shared definitions for the 74HC595 seven-segment scanner: scan FSM states,
// serial word width and the hex-to-segment table.
package seg_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO
  } state_e;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg_scan_595.sv
// Multiplexed 7-segment scanner driving a segment-byte + select-byte 595 chain,
// with a frame-synchronous valid/ready shadow load and leading-zero blanking.
module seg_scan_595
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_blank,
  output logic                  segdata,
  output logic                  shclk,
  output logic                  stclk,
  output logic                  frame_done
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(CLK_DIV - 1);

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [3:0]          bit_q, bit_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                segdata_q, segdata_d;
  logic                shclk_q, shclk_d;
  logic                stclk_q, stclk_d;
  logic                frame_done_q, frame_done_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic                pending_q, pending_d;

  logic                use_shadow;
  logic [4*DIGITS-1:0] eff_data;
  logic [DIGITS-1:0]   eff_dp;
  logic                eff_blank;
  logic [3:0]          nibble;
  logic                dp_bit, lead_zero, blanked;
  logic [6:0]          hex_seg;
  logic [7:0]          seg_raw, sel_raw, seg_byte, sel_byte;
  logic [WORD_W-1:0]   word;
  logic                phase_last;

  // Digit 0 of a frame sees the shadow contents the same cycle they are committed.
  always_comb begin
    use_shadow = pending_q && (digit_q == '0);
    eff_data   = use_shadow ? sh_data_q  : act_data_q;
    eff_dp     = use_shadow ? sh_dp_q    : act_dp_q;
    eff_blank  = use_shadow ? sh_blank_q : act_blank_q;
    nibble     = 4'h0;
    dp_bit     = 1'b0;
    lead_zero  = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (DIG_W'(j) == digit_q) begin
        nibble = eff_data[4*j +: 4];
        dp_bit = eff_dp[j];
      end
      if ((DIG_W'(j) >= digit_q) && (eff_data[4*j +: 4] != 4'h0)) begin
        lead_zero = 1'b0;
      end
    end
  end

  seg_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    blanked  = eff_blank && lead_zero && !dp_bit && (digit_q != '0);
    seg_raw  = blanked ? 8'h00 : {dp_bit, hex_seg};
    sel_raw  = 8'h01 << digit_q;
    seg_byte = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    sel_byte = SEL_ACTIVE_LOW ? ~sel_raw : sel_raw;
    word     = {seg_byte, sel_byte};
  end

  assign phase_last = (phase_q == LAST_PHASE);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    digit_d      = digit_q;
    shift_d      = shift_q;
    segdata_d    = segdata_q;
    frame_done_d = 1'b0;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pending_d    = pending_q;

    if (in_valid && !pending_q) begin
      sh_data_d  = in_data;
      sh_dp_d    = in_dp;
      sh_blank_d = in_blank;
      pending_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOAD;
          phase_d = '0;
        end
      end
      ST_LOAD: begin
        if (use_shadow) begin
          act_data_d  = sh_data_q;
          act_dp_d    = sh_dp_q;
          act_blank_d = sh_blank_q;
          pending_d   = 1'b0;
        end
        segdata_d = word[WORD_W-1];
        shift_d   = {word[WORD_W-2:0], 1'b0};
        bit_d     = 4'd0;
        phase_d   = '0;
        state_d   = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        phase_d = phase_q + 1'b1;
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        phase_d = phase_q + 1'b1;
        if (phase_last) begin
          phase_d = '0;
          if (bit_q == 4'd15) begin
            state_d = ST_LATCH_HI;
          end else begin
            bit_d     = bit_q + 4'd1;
            segdata_d = shift_q[WORD_W-1];
            shift_d   = {shift_q[WORD_W-2:0], 1'b0};
            state_d   = ST_SHIFT_LO;
          end
        end
      end
      ST_LATCH_HI: begin
        phase_d = phase_q + 1'b1;
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_LATCH_LO;
        end
      end
      ST_LATCH_LO: begin
        phase_d = phase_q + 1'b1;
        if (phase_last) begin
          phase_d      = '0;
          frame_done_d = (digit_q == LAST_DIGIT);
          if (enable) begin
            state_d = ST_LOAD;
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            digit_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        digit_d = '0;
      end
    endcase

    shclk_d = (state_d == ST_SHIFT_HI);
    stclk_d = (state_d == ST_LATCH_HI);
  end

  // Serial clocks are registered copies of the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      bit_q        <= 4'd0;
      digit_q      <= '0;
      shift_q      <= '0;
      segdata_q    <= 1'b0;
      shclk_q      <= 1'b0;
      stclk_q      <= 1'b0;
      frame_done_q <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      digit_q      <= digit_d;
      shift_q      <= shift_d;
      segdata_q    <= segdata_d;
      shclk_q      <= shclk_d;
      stclk_q      <= stclk_d;
      frame_done_q <= frame_done_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      pending_q    <= pending_d;
    end
  end

  assign in_ready   = !pending_q;
  assign segdata    = segdata_q;
  assign shclk      = shclk_q;
  assign stclk      = stclk_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_595.sv
// Scoreboard bench for seg_scan_595: expected 16-bit words are queued when data
// is loaded and compared against words reassembled from the serial outputs.
module tb_seg_scan_595;

   localparam int DIGITS       = 4;
   localparam int CLK_DIV      = 2;
   localparam bit SEG_AL       = 1'b1;
   localparam bit SEL_AL       = 1'b1;
   localparam int DIGIT_PERIOD = 34 * CLK_DIV + 1;
   localparam int FRAME_PERIOD = DIGITS * DIGIT_PERIOD;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                enable = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_blank = 1'b0;
   logic [4*DIGITS-1:0] in_data = '0;
   logic [DIGITS-1:0]   in_dp = '0;
   logic                in_ready, segdata, shclk, stclk, frame_done;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int latchCount = 0;
   int latchTimes[$];
   int fdTimes[$];
   logic [15:0] expQ[$];

   logic [15:0] capWord = '0;
   int bitCnt = 0;
   int hiCnt = 0;
   logic prevShclk = 1'b0, prevStclk = 1'b0, prevSeg = 1'b0, prevFd = 1'b0;

   seg_scan_595 #(
      .DIGITS         (DIGITS),
      .CLK_DIV        (CLK_DIV),
      .SEG_ACTIVE_LOW (SEG_AL),
      .SEL_ACTIVE_LOW (SEL_AL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_dp      (in_dp),
      .in_blank   (in_blank),
      .segdata    (segdata),
      .shclk      (shclk),
      .stclk      (stclk),
      .frame_done (frame_done)
   );

   // Free-running display clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   function automatic logic [6:0] refHex(input logic [3:0] n);
      logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   // Reference word for digit i from a load of (data, dp, blank)
   function automatic logic [15:0] refWord(input logic [15:0] data, input logic [3:0] dp, input logic blank, input int i);
      logic [7:0] seg;
      logic [7:0] sel;
      logic lz;
      lz = 1'b1;
      for (int j = DIGITS - 1; j >= i; j--) begin
         if (data[4*j +: 4] != 4'h0) lz = 1'b0;
      end
      seg = {dp[i], refHex(data[4*i +: 4])};
      if (i > 0 && blank && lz && !dp[i]) seg = 8'h00;
      sel = 8'h01 << i;
      if (SEG_AL) seg = ~seg;
      if (SEL_AL) sel = ~sel;
      return {seg, sel};
   endfunction

   task automatic pushDigits(input logic [15:0] data, input logic [3:0] dp, input logic blank, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(refWord(data, dp, blank, i));
   endtask

   // Drive a load at the current negedge and hold it until the handshake completes
   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp, input logic blank);
      logic accepted;
      accepted = 1'b0;
      in_data  = data;
      in_dp    = dp;
      in_blank = blank;
      in_valid = 1'b1;
      for (int k = 0; k < 2000 && !accepted; k++) begin
         if (in_ready) accepted = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("load_accepted", accepted, 1'b1);
      checkOutput("ready_after_accept", in_ready, 1'b0);
   endtask

   task automatic waitFrameDone(input int bound);
      logic found;
      found = 1'b0;
      for (int k = 0; k < bound && !found; k++) begin
         @(negedge clk);
         if (frame_done) begin
            found = 1'b1;
            fdTimes.push_back(cycle);
         end
      end
      checkOutput("frame_done_seen", found, 1'b1);
   endtask

   task automatic waitLatches(input int target, input int bound);
      logic found;
      found = 1'b0;
      for (int k = 0; k < bound && !found; k++) begin
         @(negedge clk);
         if (latchCount >= target) found = 1'b1;
      end
      checkOutput("latch_seen", found, 1'b1);
   endtask

   // Monitor: rebuild words from shclk/segdata and score them at each latch
   always @(negedge clk) begin
      if (!rst_n) begin
         bitCnt    = 0;
         hiCnt     = 0;
         capWord   = '0;
         prevShclk = 1'b0;
         prevStclk = 1'b0;
         prevSeg   = 1'b0;
         prevFd    = 1'b0;
      end else begin
         if (shclk && !prevShclk) begin
            capWord = {capWord[14:0], segdata};
            bitCnt++;
         end
         if (shclk && prevShclk) checkOutput("seg_stable_hi", segdata, prevSeg);
         if (frame_done) checkOutput("frame_done_width", prevFd, 1'b0);
         if (stclk) hiCnt++;
         if (!stclk && prevStclk) begin
            checkOutput("stclk_width", hiCnt, CLK_DIV);
            hiCnt = 0;
         end
         if (stclk && !prevStclk) begin
            checkOutput("bits_per_word", bitCnt, 16);
            bitCnt = 0;
            latchCount++;
            latchTimes.push_back(cycle);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", expQ.size(), 1);
            end else begin
               checkOutput("word", capWord, expQ.pop_front());
            end
         end
         prevShclk = shclk;
         prevStclk = stclk;
         prevSeg   = segdata;
         prevFd    = frame_done;
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int activity;
      logic readySeen;
      logic found;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_segdata", segdata, 1'b0);
      checkOutput("rst_shclk", shclk, 1'b0);
      checkOutput("rst_stclk", stclk, 1'b0);
      checkOutput("rst_frame_done", frame_done, 1'b0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // All-zero display: two frames expected, plus digit timing
      pushDigits(16'h0000, 4'b0000, 1'b0, DIGITS);
      pushDigits(16'h0000, 4'b0000, 1'b0, DIGITS);
      enable = 1'b1;
      waitLatches(2, 400);
      checkOutput("digit_period", latchTimes[1] - latchTimes[0], DIGIT_PERIOD);
      waitFrameDone(FRAME_PERIOD + 50);

      // Load coinciding with digit-0 LOAD lands in shadow only: applied one frame later
      pushDigits(16'h12AF, 4'b0010, 1'b0, DIGITS);
      pushDigits(16'h12AF, 4'b0010, 1'b0, DIGITS);
      applyStimulus(16'h12AF, 4'b0010, 1'b0);
      waitFrameDone(FRAME_PERIOD + 50);
      waitFrameDone(FRAME_PERIOD + 50);
      checkOutput("frame_period_a", fdTimes[1] - fdTimes[0], FRAME_PERIOD);
      checkOutput("frame_period_b", fdTimes[2] - fdTimes[1], FRAME_PERIOD);

      // Back-to-back loads mid-frame: blanked 0050, then 7E0D held until digit-0 LOAD
      repeat (100) @(negedge clk);
      pushDigits(16'h0050, 4'b0000, 1'b1, DIGITS);
      applyStimulus(16'h0050, 4'b0000, 1'b1);
      pushDigits(16'h7E0D, 4'b0100, 1'b1, DIGITS);
      in_data   = 16'h7E0D;
      in_dp     = 4'b0100;
      in_blank  = 1'b1;
      in_valid  = 1'b1;
      readySeen = 1'b0;
      found     = 1'b0;
      for (int k = 0; k < FRAME_PERIOD + 50 && !found; k++) begin
         @(negedge clk);
         if (frame_done) begin
            found = 1'b1;
            fdTimes.push_back(cycle);
         end else if (in_ready) begin
            readySeen = 1'b1;
         end
      end
      checkOutput("held_frame_done", found, 1'b1);
      checkOutput("held_until_load", readySeen, 1'b0);
      checkOutput("ready_at_load", in_ready, 1'b0);
      @(negedge clk);
      checkOutput("ready_after_load", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("second_accepted", in_ready, 1'b0);
      checkOutput("frame_period_c", fdTimes[3] - fdTimes[2], FRAME_PERIOD);
      waitFrameDone(FRAME_PERIOD + 50);
      waitFrameDone(FRAME_PERIOD + 50);

      // Drop enable in digit 2: it still latches, then the chain goes quiet
      pushDigits(16'h7E0D, 4'b0100, 1'b1, 3);
      base = latchCount;
      waitLatches(base + 2, 400);
      repeat (20) @(negedge clk);
      enable = 1'b0;
      waitLatches(base + 3, 400);
      repeat (2 * CLK_DIV + 2) @(negedge clk);
      activity = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (shclk || stclk || frame_done) activity++;
      end
      checkOutput("idle_quiet", activity, 0);
      checkOutput("idle_queue_empty", expQ.size(), 0);

      // Re-enable restarts at digit 0
      pushDigits(16'h7E0D, 4'b0100, 1'b1, DIGITS);
      enable = 1'b1;
      waitFrameDone(FRAME_PERIOD + 50);

      // Asynchronous reset mid-shift with a pending load
      applyStimulus(16'h9999, 4'b1111, 1'b0);
      repeat (20) @(negedge clk);
      #3;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      checkOutput("arst_segdata", segdata, 1'b0);
      checkOutput("arst_shclk", shclk, 1'b0);
      checkOutput("arst_stclk", stclk, 1'b0);
      checkOutput("arst_frame_done", frame_done, 1'b0);
      checkOutput("arst_in_ready", in_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pushDigits(16'h0000, 4'b0000, 1'b0, DIGITS);
      enable = 1'b1;
      waitFrameDone(FRAME_PERIOD + 50);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("sb_drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
